// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_FLUSH    = 2'd2
    } hz_state_e;

    // Wide enough for the largest legal MEM_TIMEOUT (255).
    localparam int unsigned HZ_WAIT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait holds, taken-branch flushes and
// load-use stalls, with a sticky memory-timeout flag and event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic             mem_wb_bubble,
    output logic [1:0]       state,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [HZ_WAIT_W-1:0] LP_WAIT_LAST = HZ_WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e            r_state;
    hz_state_e            w_next_state;
    logic [HZ_WAIT_W-1:0] r_wait_cnt;
    logic                 r_timeout_err;

    logic w_mem_stall;
    logic w_load_use;
    logic w_branch_entry;
    logic w_pc_stall, w_if_id_stall, w_if_id_flush, w_id_ex_hold;
    logic w_id_ex_flush, w_ex_mem_hold, w_mem_wb_bubble;

    assign w_mem_stall = mem_access & ~mem_ready;
    assign w_load_use  = ex_memread && (ex_rd != 5'd0) &&
                         ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        w_next_state    = HZ_RUN;
        w_branch_entry  = 1'b0;
        w_pc_stall      = 1'b0;
        w_if_id_stall   = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_hold    = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_hold   = 1'b0;
        w_mem_wb_bubble = 1'b0;

        if (w_mem_stall) begin
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_hold    = 1'b1;
            w_ex_mem_hold   = 1'b1;
            w_mem_wb_bubble = 1'b1;
            if ((r_state == HZ_RUN) || (r_state == HZ_MEM_WAIT)) begin
                w_next_state = HZ_MEM_WAIT;
            end
        end else begin
            case (r_state)
                // The release cycle of MEM_WAIT services a branch or load that
                // was held in EX, so it is evaluated the same way as RUN.
                HZ_RUN, HZ_MEM_WAIT: begin
                    if (ex_branch_taken) begin
                        w_if_id_flush  = 1'b1;
                        w_id_ex_flush  = 1'b1;
                        w_branch_entry = 1'b1;
                        w_next_state   = HZ_FLUSH;
                    end else if (w_load_use) begin
                        w_pc_stall    = 1'b1;
                        w_if_id_stall = 1'b1;
                        w_id_ex_flush = 1'b1;
                    end
                end
                HZ_FLUSH: begin
                    w_if_id_flush = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= HZ_RUN;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == HZ_RUN) && w_mem_stall) begin
                r_wait_cnt <= '0;
            end else if ((r_state == HZ_MEM_WAIT) && w_mem_stall &&
                         (r_wait_cnt != LP_WAIT_LAST)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if ((r_state == HZ_MEM_WAIT) && w_mem_stall && (r_wait_cnt == LP_WAIT_LAST)) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Reset forces every pipeline control low, independent of the inputs.
    assign pc_stall        = w_pc_stall      & ~rst;
    assign if_id_stall     = w_if_id_stall   & ~rst;
    assign if_id_flush     = w_if_id_flush   & ~rst;
    assign id_ex_hold      = w_id_ex_hold    & ~rst;
    assign id_ex_flush     = w_id_ex_flush   & ~rst;
    assign ex_mem_hold     = w_ex_mem_hold   & ~rst;
    assign mem_wb_bubble   = w_mem_wb_bubble & ~rst;
    assign state           = r_state;
    assign mem_timeout_err = r_timeout_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_stall),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_branch_entry & ~rst),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a queue-based scoreboard of expected outputs.
module tb_hazard_ctrl;

    localparam int unsigned CW = 4;
    // {pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_bubble}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_HOLD = 7'b1101011;
    localparam logic [6:0] C_BR   = 7'b0010100;
    localparam logic [6:0] C_FL   = 7'b0010000;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_MW   = 2'd1;
    localparam logic [1:0] S_FL   = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs2, ex_memread, ex_branch_taken, mem_access, mem_ready;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_flush;
    logic          ex_mem_hold, mem_wb_bubble, mem_timeout_err;
    logic [1:0]    state;
    logic [CW-1:0] stall_count, flush_count;

    typedef struct {
        string       tag;
        logic [17:0] vec;
    } exp_t;

    exp_t          sb[$];
    int            n_run  = 0;
    int            n_fail = 0;
    logic [CW-1:0] t_stall;
    logic [CW-1:0] t_flush;
    logic          t_err;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_access      (mem_access),
        .mem_ready       (mem_ready),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_hold      (id_ex_hold),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_hold     (ex_mem_hold),
        .mem_wb_bubble   (mem_wb_bubble),
        .state           (state),
        .mem_timeout_err (mem_timeout_err),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic mr, input logic br,
                         input logic ma, input logic rdy);
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_uses_rs2     = u2;
        ex_rd           = rd;
        ex_memread      = mr;
        ex_branch_taken = br;
        mem_access      = ma;
        mem_ready       = rdy;
    endtask

    task automatic chk(input string tag, input logic [6:0] ctl, input logic [1:0] st);
        exp_t        e;
        exp_t        g;
        logic [17:0] obs;
        e.tag = tag;
        e.vec = {ctl, st, t_err, t_stall, t_flush};
        sb.push_back(e);
        @(negedge clk);
        g   = sb.pop_front();
        obs = {pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold,
               mem_wb_bubble, state, mem_timeout_err, stall_count, flush_count};
        n_run++;
        assert (obs === g.vec)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", g.tag, obs, g.vec);
        end
        if (ctl[6] && (t_stall != '1)) t_stall++;
        if (ctl[4] && ctl[2]) t_flush++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        t_stall = '0;
        t_flush = '0;
        t_err   = 1'b0;
        rst     = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst_forces_zero", C_NONE, S_RUN);

        tick(); rst = 1'b0; drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle", C_NONE, S_RUN);

        // load-use detection
        tick(); drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_rs1", C_LU, S_RUN);
        tick(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_one_cycle", C_NONE, S_RUN);
        tick(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_rd0", C_NONE, S_RUN);
        tick(); drive(5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_rs2", C_LU, S_RUN);
        tick(); drive(5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_rs2_unused", C_NONE, S_RUN);
        tick(); drive(5'd6, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_nomatch", C_NONE, S_RUN);
        tick(); drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_not_load", C_NONE, S_RUN);

        // taken branch, then branch held through FLUSH
        tick(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("br_take", C_BR, S_RUN);
        tick(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("br_flush", C_FL, S_FL);
        tick(); chk("br_back_run", C_NONE, S_RUN);
        tick(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("br2_take", C_BR, S_RUN);
        tick(); chk("br2_ignored_in_flush", C_FL, S_FL);
        tick(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("br2_back_run", C_NONE, S_RUN);

        // branch beats load-use; no load-use in FLUSH
        tick(); drive(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("br_over_lu", C_BR, S_RUN);
        tick(); drive(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("no_lu_in_flush", C_FL, S_FL);
        tick(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("prio_back_run", C_NONE, S_RUN);

        // three-cycle memory wait
        tick(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mw_enter", C_HOLD, S_RUN);
        tick(); chk("mw_hold1", C_HOLD, S_MW);
        tick(); chk("mw_hold2", C_HOLD, S_MW);
        tick(); mem_ready = 1'b1;
        chk("mw_ready", C_NONE, S_MW);
        tick(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mw_back_run", C_NONE, S_RUN);

        // timeout after the fourth MEM_WAIT cycle, sticky afterwards
        tick(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("to_enter", C_HOLD, S_RUN);
        tick(); chk("to_wait1", C_HOLD, S_MW);
        tick(); chk("to_wait2", C_HOLD, S_MW);
        tick(); chk("to_wait3", C_HOLD, S_MW);
        tick(); chk("to_wait4", C_HOLD, S_MW);
        t_err = 1'b1;
        tick(); chk("to_set", C_HOLD, S_MW);
        tick(); mem_ready = 1'b1;
        chk("to_sticky_ready", C_NONE, S_MW);
        tick(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_sticky_run", C_NONE, S_RUN);

        // branch masked by memory stall; stall counter saturates
        tick(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("br_masked", C_HOLD, S_RUN);
        for (int i = 0; i < 5; i++) begin
            tick(); chk("br_masked_wait", C_HOLD, S_MW);
        end
        tick(); chk("stall_saturated", C_HOLD, S_MW);

        // reset mid-MEM_WAIT
        tick(); rst = 1'b1;
        t_stall = '0;
        t_flush = '0;
        t_err   = 1'b0;
        chk("rst_mid_wait", C_NONE, S_RUN);
        tick(); chk("rst_held", C_NONE, S_RUN);
        tick(); rst = 1'b0; mem_access = 1'b0;
        chk("post_rst_branch", C_BR, S_RUN);
        tick(); ex_branch_taken = 1'b0;
        chk("post_rst_flush", C_FL, S_FL);
        tick(); chk("post_rst_run", C_NONE, S_RUN);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: MEM_WAIT cycles before timeout flag; legal 2..255.
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset; asynchronous, active-high.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, 5 each: source registers of the instruction in ID.
REQ-006 SHALL have port id_uses_rs2, input, 1: ID instruction reads rs2.
REQ-007 SHALL have ports ex_rd (input, 5) and ex_memread (input, 1): destination register and load flag of the instruction in EX.
REQ-008 SHALL have port ex_branch_taken, input, 1: branch resolved taken in EX.
REQ-009 SHALL have ports mem_access (input, 1) and mem_ready (input, 1): MEM-stage data access request and memory completion.
REQ-010 SHALL have outputs pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold and mem_wb_bubble, 1 each: pipeline-register controls.
REQ-011 SHALL have output state, 2: current FSM state.
REQ-012 SHALL have output mem_timeout_err, 1: sticky memory-timeout flag.
REQ-013 SHALL have outputs stall_count and flush_count, CNT_W each: saturating event counters.

Function
REQ-014 FSM states SHALL be RUN=0, MEM_WAIT=1, FLUSH=2; encoding 3 is unreachable and SHALL return to RUN on the next edge.
REQ-015 mem_stall = mem_access & ~mem_ready; with it set, outputs SHALL be pc_stall, if_id_stall, id_ex_hold, ex_mem_hold and mem_wb_bubble = 1, with both flushes 0, in any state, same cycle.
REQ-016 RUN with mem_stall SHALL go to MEM_WAIT, clear wait counter; MEM_WAIT SHALL stay while mem_stall and return to RUN the cycle after mem_ready=1 or mem_access=0.
REQ-017 Without mem_stall, in RUN with ex_branch_taken=1: if_id_flush=1, id_ex_flush=1, pc not stalled; next state SHALL be FLUSH.
REQ-018 FLUSH: if_id_flush=1 for exactly one cycle (fetch latency bubble), then RUN; ex_branch_taken SHALL be ignored in FLUSH.
REQ-019 Load-use: in RUN, no mem_stall, no taken branch, ex_memread=1, ex_rd!=0 and (ex_rd==id_rs1 or (id_uses_rs2 and ex_rd==id_rs2)) -> pc_stall=1, if_id_stall=1, id_ex_flush=1 for that cycle only; state stays RUN.
REQ-020 Priority SHALL be mem_stall > branch flush > load-use; a branch masked by mem_stall stays pending because EX is held, and is serviced when the stall ends.
REQ-021 ex_rd=0 SHALL never cause a load-use stall.
REQ-022 MEM_WAIT wait counter SHALL increment each cycle; on reaching MEM_TIMEOUT-1 with mem_stall still 1, mem_timeout_err SHALL set and stay set until reset; the FSM keeps waiting.
REQ-023 stall_count SHALL increment every cycle pc_stall=1; flush_count SHALL increment once per taken-branch entry into FLUSH; both saturate at all-ones.
REQ-024 Outputs not driven by a rule above SHALL be 0.

Reset
REQ-025 Asserting rst SHALL immediately force state=RUN, counters=0, mem_timeout_err=0, wait counter=0.
REQ-026 While rst=1, all pipeline-control outputs SHALL be 0 regardless of inputs.
REQ-027 Reset asserted mid-MEM_WAIT or mid-FLUSH SHALL abandon that operation; the first edge after release evaluates from RUN.

Structure
REQ-028 Package hazard_pkg SHALL hold the state enum (HZ_RUN, HZ_MEM_WAIT, HZ_FLUSH) and the wait-counter width constant.
REQ-029 One sub-module sat_counter (parameter W; inputs clk, rst, inc; output count) SHALL implement both event counters.

Verification
REQ-030 ex_memread=1, ex_rd=5, id_rs1=5 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_count=1.
REQ-031 Same as REQ-030 with ex_rd=0 -> no stall; stall_count=0.
REQ-032 ex_branch_taken for 1 cycle -> if_id_flush=1 for 2 cycles, id_ex_flush=1 for 1, state RUN->FLUSH->RUN, flush_count=1.
REQ-033 mem_access=1, mem_ready=0 for 3 cycles then ready -> holds asserted 3 cycles, state MEM_WAIT, stall_count=3, no timeout.
REQ-034 MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout_err=1 after the 4th wait cycle, still 1 after ready; cleared only by rst.
REQ-035 Branch and mem_stall together, then rst mid-MEM_WAIT -> holds win with no flush; after reset state=RUN, counters=0, outputs 0.
